// File: rtl/adder_sched_pkg.sv
// Shared lane geometry, tag format and small helpers for the adder lane scheduler.
package adder_sched_pkg;

  localparam int LANES    = 4;
  localparam int DW       = 16;
  localparam int MAX_ID_W = 3;

  typedef logic [LANES*DW-1:0] lane_vec_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                     = 1'b1;
        grant[cand[IDX_W-1:0]] = 1'b1;
        idx                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_lane_sched.sv
// Shares one external 4-lane registered adder among NUM_REQ requesters: round-robin
// issue, a tag pipe that shadows the adder, and a credited result FIFO.
module adder_lane_sched
  import adder_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*LANES*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*LANES*DATA_WIDTH-1:0] req_b,
  output logic [LANES*DATA_WIDTH-1:0]         add_a,
  output logic [LANES*DATA_WIDTH-1:0]         add_b,
  input  logic [LANES*DATA_WIDTH-1:0]         add_sum,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic [LANES*DATA_WIDTH-1:0]         rsp_sum,
  output logic                                busy
);

  localparam int VW   = LANES * DATA_WIDTH;
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef logic [AW:0] cnt_t;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic               win_any;
  logic               issue_ok;
  logic               fire;
  logic               push;
  logic               pop;
  logic               full;
  logic               inflight;
  cnt_t               occ;
  cnt_t               count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  tag_t               pipe [LATENCY];
  tag_t               tail;
  logic               unused_tag_bits;
  logic [VW-1:0]      sum_mem [FIFO_DEPTH];
  logic [ID_W-1:0]    id_mem  [FIFO_DEPTH];

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(win_grant),
    .idx  (win_idx),
    .any  (win_any)
  );

  // occ counts every op that will eventually occupy a FIFO slot, so the adder can never overrun it
  assign issue_ok  = !rst && (occ < cnt_t'(FIFO_DEPTH));
  assign fire      = win_any && issue_ok;
  assign req_ready = issue_ok ? win_grant : '0;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (fire) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win_idx == ID_W'(i)) begin
          add_a = req_a[i*VW +: VW];
          add_b = req_b[i*VW +: VW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= ID_W'(wrap_inc(int'(win_idx), NUM_REQ));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{valid: fire, id: MAX_ID_W'(win_idx)};
      for (int s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign tail            = pipe[LATENCY-1];
  assign push            = tail.valid;
  assign unused_tag_bits = ^tail.id;

  always_comb begin
    inflight = 1'b0;
    for (int s = 0; s < LATENCY; s++) inflight = inflight | pipe[s].valid;
  end

  // A pop returns its credit only from the next cycle on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   occ <= occ + cnt_t'(1);
        2'b01:   occ <= occ - cnt_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr] <= add_sum;
      id_mem[wr_ptr]  <= tail.id[ID_W-1:0];
    end
  end

  assign full      = (count == cnt_t'(FIFO_DEPTH));
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_sum   = rsp_valid ? sum_mem[rd_ptr] : '0;
  assign rsp_id    = rsp_valid ? id_mem[rd_ptr] : '0;
  assign busy      = inflight || rsp_valid;

  always @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end

endmodule

// File: tb/tb_adder_lane_sched.sv
// Directed bench for adder_lane_sched: a 2-requester and a 3-requester instance,
// each with a registered adder model and a scoreboard of expected responses.
module tb_adder_lane_sched;
  import adder_sched_pkg::*;

  typedef struct {
    int        id;
    lane_vec_t sum;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   rsp3_seen;

  logic [1:0]   req_valid2, req_ready2;
  logic [127:0] req_a2, req_b2;
  lane_vec_t    add_a2, add_b2, add_sum2, rsp_sum2;
  logic         rsp_valid2, rsp_ready2, busy2;
  logic [0:0]   rsp_id2;

  logic [2:0]   req_valid3, req_ready3;
  logic [191:0] req_a3, req_b3;
  lane_vec_t    add_a3, add_b3, add_sum3, rsp_sum3;
  logic         rsp_valid3, rsp_ready3, busy3;
  logic [1:0]   rsp_id3;

  exp_t sb2[$];
  exp_t sb3[$];
  exp_t e2;
  exp_t e3;

  lane_vec_t ra0, rb0, ra1, rb1;

  adder_lane_sched #(.DATA_WIDTH(16), .NUM_REQ(2), .FIFO_DEPTH(4), .LATENCY(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2), .rsp_sum(rsp_sum2),
    .busy(busy2)
  );

  adder_lane_sched #(.DATA_WIDTH(16), .NUM_REQ(3), .FIFO_DEPTH(4), .LATENCY(1)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_sum(rsp_sum3),
    .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic lane_vec_t mk(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic lane_vec_t lane_add(input lane_vec_t a, input lane_vec_t b);
    lane_vec_t r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
    return r;
  endfunction

  // External adders: one register stage, cleared by the same reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_sum2 <= '0;
      add_sum3 <= '0;
    end else begin
      add_sum2 <= lane_add(add_a2, add_b2);
      add_sum3 <= lane_add(add_a3, add_b3);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input lane_vec_t a0, input lane_vec_t b0,
                               input lane_vec_t a1, input lane_vec_t b1, input logic rdy);
    @(posedge clk);
    #1;
    req_valid2 = valid;
    req_a2     = {a1, a0};
    req_b2     = {b1, b0};
    rsp_ready2 = rdy;
    @(negedge clk);
  endtask

  task automatic applyStimulus3(input logic [2:0] valid, input lane_vec_t a2, input lane_vec_t b2,
                                input logic rdy);
    @(posedge clk);
    #1;
    req_valid3 = valid;
    req_a3     = {a2, 128'd0};
    req_b3     = {b2, 128'd0};
    rsp_ready3 = rdy;
    @(negedge clk);
  endtask

  // Scoreboards: check the popped head first, then record this cycle's accepted ops
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("ready_onehot2", 64'($countones(req_ready2) <= 1), 64'd1);
      if (rsp_valid2 && rsp_ready2) begin
        checkOutput("rsp_expected2", 64'(sb2.size() != 0), 64'd1);
        if (sb2.size() != 0) begin
          e2 = sb2.pop_front();
          checkOutput("rsp_id2", 64'(rsp_id2), 64'(e2.id));
          checkOutput("rsp_sum2", rsp_sum2, e2.sum);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid2[i] && req_ready2[i])
          sb2.push_back('{i, lane_add(req_a2[i*64 +: 64], req_b2[i*64 +: 64])});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("ready_onehot3", 64'($countones(req_ready3) <= 1), 64'd1);
      if (rsp_valid3 && rsp_ready3) begin
        rsp3_seen++;
        checkOutput("rsp_expected3", 64'(sb3.size() != 0), 64'd1);
        if (sb3.size() != 0) begin
          e3 = sb3.pop_front();
          checkOutput("rsp_id3", 64'(rsp_id3), 64'(e3.id));
          checkOutput("rsp_sum3", rsp_sum3, e3.sum);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (req_valid3[i] && req_ready3[i])
          sb3.push_back('{i, lane_add(req_a3[i*64 +: 64], req_b3[i*64 +: 64])});
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rsp3_seen  = 0;
    rst        = 1'b1;
    req_valid2 = 2'b11;
    req_a2     = '1;
    req_b2     = '1;
    rsp_ready2 = 1'b1;
    req_valid3 = 3'b111;
    req_a3     = '1;
    req_b3     = '1;
    rsp_ready3 = 1'b1;

    // Reset: grants suppressed even with requests pending
    @(negedge clk);
    checkOutput("rst_ready2", 64'(req_ready2), 64'd0);
    checkOutput("rst_ready3", 64'(req_ready3), 64'd0);
    checkOutput("rst_rsp_valid2", 64'(rsp_valid2), 64'd0);
    checkOutput("rst_busy2", 64'(busy2), 64'd0);
    checkOutput("rst_add_a2", add_a2, 64'd0);
    checkOutput("rst_rsp_sum2", rsp_sum2, 64'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req_valid2 = '0;
    req_valid3 = '0;
    $display("[TB] reset released");

    // Single op with two-cycle response latency
    applyStimulus(2'b01, mk(1, 2, 3, 4), mk(10, 20, 30, 40), '0, '0, 1'b1);
    checkOutput("t1_ready", 64'(req_ready2), 64'd1);
    checkOutput("t1_add_a", add_a2, mk(1, 2, 3, 4));
    checkOutput("t1_add_b", add_b2, mk(10, 20, 30, 40));
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t1_rsp_early", 64'(rsp_valid2), 64'd0);
    checkOutput("t1_busy", 64'(busy2), 64'd1);
    checkOutput("t1_idle_add_a", add_a2, 64'd0);
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t1_rsp_valid", 64'(rsp_valid2), 64'd1);
    checkOutput("t1_rsp_id", 64'(rsp_id2), 64'd0);
    checkOutput("t1_rsp_sum", rsp_sum2, mk(11, 22, 33, 44));
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t1_busy_done", 64'(busy2), 64'd0);

    // Lone req1 op, leaving the pointer back at req0
    applyStimulus(2'b10, '0, '0, mk(5, 6, 7, 8), mk(1, 1, 1, 1), 1'b1);
    checkOutput("t1b_ready", 64'(req_ready2), 64'd2);
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t1b_rsp_id", 64'(rsp_id2), 64'd1);
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);

    // Both requesters streaming: alternating grants, one response per cycle
    for (int k = 0; k < 8; k++) begin
      ra0 = {$urandom, $urandom};
      rb0 = {$urandom, $urandom};
      ra1 = {$urandom, $urandom};
      rb1 = {$urandom, $urandom};
      applyStimulus(2'b11, ra0, rb0, ra1, rb1, 1'b1);
      checkOutput("t2_grant", 64'(req_ready2), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k >= 2) begin
        checkOutput("t2_rsp_valid", 64'(rsp_valid2), 64'd1);
        checkOutput("t2_rsp_id", 64'(rsp_id2), 64'(k % 2));
      end
    end
    for (int k = 0; k < 3; k++) applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t2_busy_done", 64'(busy2), 64'd0);

    // Lane wraparound and lane independence
    applyStimulus(2'b01, mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                  mk(16'h0002, 16'h0002, 16'h0002, 16'h0002), '0, '0, 1'b1);
    checkOutput("t3_ready", 64'(req_ready2), 64'd1);
    applyStimulus(2'b01, mk(16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF),
                  mk(16'h8000, 16'h0001, 16'h0000, 16'hFFFF), '0, '0, 1'b1);
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t3_wrap_sum", rsp_sum2, mk(16'h0001, 16'h0001, 16'h0001, 16'h0001));
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t3_lane_sum", rsp_sum2, mk(16'h0000, 16'h8000, 16'h0000, 16'hFFFE));
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);

    // Back-pressure: four credits, then stall; a pop frees a credit one cycle later
    for (int k = 0; k < 7; k++) begin
      ra0 = {$urandom, $urandom};
      rb0 = {$urandom, $urandom};
      applyStimulus(2'b01, ra0, rb0, '0, '0, 1'b0);
      checkOutput("t4_credit", 64'(req_ready2), (k < 4) ? 64'd1 : 64'd0);
    end
    applyStimulus(2'b01, ra0, rb0, '0, '0, 1'b1);
    checkOutput("t4_no_reuse", 64'(req_ready2), 64'd0);
    checkOutput("t4_full_valid", 64'(rsp_valid2), 64'd1);
    applyStimulus(2'b01, {$urandom, $urandom}, {$urandom, $urandom}, '0, '0, 1'b1);
    checkOutput("t4_reaccept", 64'(req_ready2), 64'd1);
    for (int k = 0; k < 4; k++) applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t4_busy_done", 64'(busy2), 64'd0);

    // Reset with two queued results and one in flight
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, {$urandom, $urandom}, {$urandom, $urandom}, '0, '0, 1'b0);
      checkOutput("t5_fill", 64'(req_ready2), 64'd1);
    end
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b0);
    checkOutput("t5_pre_valid", 64'(rsp_valid2), 64'd1);
    checkOutput("t5_pre_busy", 64'(busy2), 64'd1);
    #1;
    rst        = 1'b1;
    req_valid2 = 2'b11;
    #1;
    checkOutput("t5_rst_valid", 64'(rsp_valid2), 64'd0);
    checkOutput("t5_rst_busy", 64'(busy2), 64'd0);
    checkOutput("t5_rst_ready", 64'(req_ready2), 64'd0);
    sb2.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req_a2     = {{$urandom, $urandom}, {$urandom, $urandom}};
    req_b2     = {{$urandom, $urandom}, {$urandom, $urandom}};
    rsp_ready2 = 1'b1;
    @(negedge clk);
    checkOutput("t5_first_grant", 64'(req_ready2), 64'd1);
    checkOutput("t5_no_stale0", 64'(rsp_valid2), 64'd0);
    applyStimulus(2'b11, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    checkOutput("t5_second_grant", 64'(req_ready2), 64'd2);
    checkOutput("t5_no_stale1", 64'(rsp_valid2), 64'd0);
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t5_new_rsp", 64'(rsp_valid2), 64'd1);
    checkOutput("t5_new_id", 64'(rsp_id2), 64'd0);
    for (int k = 0; k < 2; k++) applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    checkOutput("t5_busy_done", 64'(busy2), 64'd0);
    checkOutput("sb2_drained", 64'(sb2.size()), 64'd0);

    // Three requesters, only req2 active: granted every cycle
    for (int k = 0; k < 6; k++) begin
      applyStimulus3(3'b100, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      checkOutput("t6_grant", 64'(req_ready3), 64'd4);
      if (k >= 2) begin
        checkOutput("t6_rsp_valid", 64'(rsp_valid3), 64'd1);
        checkOutput("t6_rsp_id", 64'(rsp_id3), 64'd2);
      end
    end
    for (int k = 0; k < 3; k++) applyStimulus3(3'b000, '0, '0, 1'b1);
    checkOutput("t6_busy_done", 64'(busy3), 64'd0);
    checkOutput("t6_rsp_count", 64'(rsp3_seen), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
